// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the psum datapath.
package diff_demo_pkg;

  localparam int unsigned PSUM_WIDTH    = 16;
  localparam int unsigned PSUM_ROW_W    = 6 * PSUM_WIDTH;
  localparam int unsigned ROWS_PER_TILE = 3;

  typedef enum logic [1:0] {
    ARB,
    WAIT,
    SEND
  } drain_state_t;

endpackage

// File: rtl/psum_drain_arbiter_if.sv
// Valid/ready psum row stream from the drain arbiter to the accumulation stage.
interface psum_drain_arbiter_if #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned ROW_W  = diff_demo_pkg::PSUM_ROW_W
);

  localparam int unsigned SRC_W = $clog2(NUM_PE);

  logic             psum_valid;
  logic             psum_ready;
  logic [ROW_W-1:0] psum_data;
  logic [SRC_W-1:0] psum_src;
  logic [1:0]       psum_row;
  logic             psum_last;

  modport master (
    output psum_valid,
    output psum_data,
    output psum_src,
    output psum_row,
    output psum_last,
    input  psum_ready
  );

  modport slave (
    input  psum_valid,
    input  psum_data,
    input  psum_src,
    input  psum_row,
    input  psum_last,
    output psum_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_PE = 4
) (
  input  logic [NUM_PE-1:0]         req,
  input  logic [$clog2(NUM_PE)-1:0] ptr,
  output logic [NUM_PE-1:0]         gnt,
  output logic [$clog2(NUM_PE)-1:0] gnt_idx,
  output logic                      gnt_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_PE);

  int unsigned cand;

  // Walk the requesters starting at ptr, wrapping modulo NUM_PE; keep the first hit.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      cand = (32'(ptr) + i) % NUM_PE;
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = IDX_W'(cand);
        gnt[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_drain_arbiter.sv
// Round-robin drain of NUM_PE psum FIFOs onto one row-serial valid/ready stream.
module psum_drain_arbiter #(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned PSUM_WIDTH = diff_demo_pkg::PSUM_WIDTH,
  parameter int unsigned ROW_W      = 6 * PSUM_WIDTH,
  parameter int unsigned TILE_W     = 3 * ROW_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [NUM_PE-1:0]        fifo_empty_i,
  input  logic [NUM_PE*TILE_W-1:0] fifo_dout_i,
  output logic [NUM_PE-1:0]        fifo_rd_en_o,
  output logic                     busy_o,
  psum_drain_arbiter_if.master     out_if
);

  import diff_demo_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_PE);

  drain_state_t                state;
  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            src_q;
  logic [1:0]                  beat;
  logic [2:0][ROW_W-1:0]       hold;
  logic                        valid_q;
  logic                        last_q;
  logic                        busy_q;

  logic [NUM_PE-1:0]           gnt;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        gnt_valid;

  rr_arbiter #(.NUM_PE(NUM_PE)) u_rr_arbiter (
    .req       (~fifo_empty_i),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Pop strobe is combinational so the FIFO's registered read lands in WAIT.
  assign fifo_rd_en_o = (state == ARB && en_i) ? gnt : '0;

  assign busy_o            = busy_q;
  assign out_if.psum_valid = valid_q;
  assign out_if.psum_src   = src_q;
  assign out_if.psum_row   = beat;
  assign out_if.psum_last  = last_q;

  // Row select from the held tile; row 0 is the low slice.
  always_comb begin
    case (beat)
      2'd0:    out_if.psum_data = hold[0];
      2'd1:    out_if.psum_data = hold[1];
      2'd2:    out_if.psum_data = hold[2];
      default: out_if.psum_data = '0;
    endcase
  end

  // Drain FSM: grant in ARB, capture FIFO data in WAIT, emit three rows in SEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      rr_ptr  <= '0;
      src_q   <= '0;
      beat    <= '0;
      hold    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (en_i && gnt_valid) begin
            src_q  <= gnt_idx;
            rr_ptr <= (32'(gnt_idx) == NUM_PE - 1) ? '0 : gnt_idx + 1'b1;
            busy_q <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          hold    <= fifo_dout_i[32'(src_q)*TILE_W +: TILE_W];
          beat    <= '0;
          last_q  <= 1'b0;
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (out_if.psum_ready) begin
            if (beat != 2'd2) begin
              beat   <= beat + 2'd1;
              last_q <= (beat == 2'd1);
            end else begin
              beat    <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state   <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain_arbiter.sv
// Cycle-accurate directed bench for psum_drain_arbiter.
module tb_psum_drain_arbiter;

  localparam int unsigned NP     = 4;
  localparam int unsigned PW     = diff_demo_pkg::PSUM_WIDTH;
  localparam int unsigned ROW_W  = 6 * PW;
  localparam int unsigned TILE_W = 3 * ROW_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [NP-1:0]         fifo_empty;
  logic [NP*TILE_W-1:0]  fifo_dout;
  logic [NP-1:0]         fifo_rd_en;
  logic                  busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  psum_drain_arbiter_if #(.NUM_PE(NP), .ROW_W(ROW_W)) bus ();

  psum_drain_arbiter #(.NUM_PE(NP)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_en_o (fifo_rd_en),
    .busy_o       (busy),
    .out_if       (bus)
  );

  // Psum (row r, column c) of PE k's tile reads {A+r, k, c+1}.
  function automatic logic [ROW_W-1:0] row_pat(int k, int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < 6; c++) v[c*PW +: PW] = PW'({4'(10 + r), 4'(k), 8'(c + 1)});
    return v;
  endfunction

  function automatic logic [TILE_W-1:0] tile_pat(int k);
    return {row_pat(k, 2), row_pat(k, 1), row_pat(k, 0)};
  endfunction

  // Registered-read FIFO: good data only in the cycle after a pop, inverted junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < NP; k++)
      fifo_dout[k*TILE_W +: TILE_W] <= fifo_rd_en[k] ? tile_pat(k) : ~tile_pat(k);
  end

  typedef struct {
    logic          rst;
    logic          en;
    logic [NP-1:0] empty;
    logic          ready;
    logic [NP-1:0] rd;
    logic          valid;
    logic [1:0]    src;
    logic [1:0]    row;
    logic          last;
    logic          busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic e, logic [NP-1:0] emp, logic rdy,
                              logic [NP-1:0] rd, logic v, logic [1:0] s,
                              logic [1:0] rw, logic l, logic b);
    vec_t x;
    x.rst = r; x.en = e; x.empty = emp; x.ready = rdy;
    x.rd = rd; x.valid = v; x.src = s; x.row = rw; x.last = l; x.busy = b;
    vq.push_back(x);
  endfunction

  // Grant cycle, WAIT cycle and three ready beats for one tile from PE g.
  function automatic void add_tile(logic [NP-1:0] emp, logic [1:0] g, logic [1:0] prev_src);
    add(0, 1, emp, 1, NP'(1) << g, 0, prev_src, 0, 0, 0);
    add(0, 1, '1, 1, 0, 0, g, 0, 0, 1);
    add(0, 1, '1, 1, 0, 1, g, 0, 0, 1);
    add(0, 1, '1, 1, 0, 1, g, 1, 0, 1);
    add(0, 1, '1, 1, 0, 1, g, 2, 1, 1);
  endfunction

  logic [9:0] act, exp_v;
  int unsigned beats;
  logic        done;
  logic [1:0]  got_src;

  initial begin
    // Idle with every FIFO empty
    for (int i = 0; i < 20; i++) add(0, 1, '1, 1, 0, 0, 0, 0, 0, 0);
    // Single tile from PE2; pointer ends at 3
    add_tile(4'b1011, 2, 0);
    add(0, 1, '1, 1, 0, 0, 2, 0, 0, 0);
    // Sync reset while idle restores src and pointer
    add(1, 0, '1, 1, 0, 0, 2, 0, 0, 0);
    // All four requesting: one tile each in order 0,1,2,3
    for (int g = 0; g < 4; g++) begin
      add(0, 1, 4'b0000, 1, NP'(1) << g, 0, (g == 0) ? 2'd0 : 2'(g - 1), 0, 0, 0);
      add(0, 1, 4'b0000, 1, 0, 0, 2'(g), 0, 0, 1);
      for (int r = 0; r < 3; r++) add(0, 1, 4'b0000, 1, 0, 1, 2'(g), 2'(r), r == 2, 1);
    end
    // PE1 with 7-cycle stall on row 1; PE1 stays non-empty, en drops mid-tile
    add(0, 1, 4'b1101, 1, 4'b0010, 0, 3, 0, 0, 0);
    add(0, 1, 4'b1101, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 4'b1101, 1, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 4'b1101, 0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 4'b1101, 1, 0, 1, 1, 1, 0, 1);
    add(0, 0, 4'b1101, 1, 0, 1, 1, 2, 1, 1);
    add(0, 0, 4'b1101, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 4'b1101, 1, 0, 0, 1, 0, 0, 0);
    // Pointer wrap: serve PE3, then PE0 beats PE3
    add_tile(4'b0111, 3, 1);
    add_tile(4'b0110, 0, 3);
    add(0, 0, '1, 1, 0, 0, 0, 0, 0, 0);
    // Reset during row 1 of a PE1 tile, then PE1 and PE3 request: PE1 wins from ptr 0
    add(0, 1, 4'b1101, 1, 4'b0010, 0, 0, 0, 0, 0);
    add(0, 1, 4'b1101, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 4'b1101, 1, 0, 1, 1, 0, 0, 1);
    add(1, 1, 4'b1101, 1, 0, 1, 1, 1, 0, 1);
    add_tile(4'b0101, 1, 0);
    add(0, 0, '1, 1, 0, 0, 1, 0, 0, 0);

    rst = 1'b1; en = 1'b0; fifo_empty = '1; bus.psum_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    act = {fifo_rd_en, bus.psum_valid, bus.psum_src, bus.psum_row, bus.psum_last, busy};
    if (act != '0) begin
      fails++;
      $display("FAIL reset_state: got %b expected 0000000000", act);
    end
    @(posedge clk); #1;

    foreach (vq[i]) begin
      rst = vq[i].rst; en = vq[i].en; fifo_empty = vq[i].empty; bus.psum_ready = vq[i].ready;
      @(negedge clk);
      act   = {fifo_rd_en, bus.psum_valid, bus.psum_src, bus.psum_row, bus.psum_last, busy};
      exp_v = {vq[i].rd, vq[i].valid, vq[i].src, vq[i].row, vq[i].last, vq[i].busy};
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL vec%0d ctrl {rd,valid,src,row,last,busy}: got %b expected %b", i, act, exp_v);
      end
      if (vq[i].valid) begin
        tests++;
        if (bus.psum_data !== row_pat(int'(vq[i].src), int'(vq[i].row))) begin
          fails++;
          $display("FAIL vec%0d data: got %h expected %h", i, bus.psum_data,
                   row_pat(int'(vq[i].src), int'(vq[i].row)));
        end
      end
      @(posedge clk); #1;
    end

    // Bounded wait for a full PE2 tile: pop, then exactly three beats ending in last
    rst = 1'b0; en = 1'b1; fifo_empty = 4'b1011; bus.psum_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (fifo_rd_en !== 4'b0100) begin
      fails++;
      $display("FAIL seq_pop: got %b expected 0100", fifo_rd_en);
    end
    @(posedge clk); #1;
    fifo_empty = '1;
    beats = 0; done = 1'b0; got_src = '0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (bus.psum_valid) begin
        beats++;
        if (bus.psum_last) begin
          done = 1'b1;
          got_src = bus.psum_src;
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (!done || beats != 3 || got_src != 2'd2) begin
      fails++;
      $display("FAIL seq_tile: done=%0b beats=%0d src=%0d expected done=1 beats=3 src=2",
               done, beats, got_src);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
